// File: rtl/dsp_pkg.sv
// Shared DSP-path constants, word types and saturation limit helpers.
package dsp_pkg;

  localparam int unsigned IN_W  = 48;
  localparam int unsigned OUT_W = 18;

  typedef logic signed [IN_W-1:0]  p_word_t;
  typedef logic signed [OUT_W-1:0] out_word_t;

  // Largest value representable in a signed word of the given width.
  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed word of the given width.
  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/dsp_post_round_sat_if.sv
// Stream signals between the DSP slice, the post stage and its consumer.
interface dsp_post_round_sat_if #(
  parameter int unsigned IN_W  = 48,
  parameter int unsigned OUT_W = 18
) ();

  logic [IN_W-1:0]  p_in;
  logic             p_valid;
  logic             p_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // Stage view: receives P, produces the output stream.
  modport slave (
    input  p_in, p_valid, out_ready,
    output p_ready, out_data, out_valid
  );

  // Environment view: supplies P, consumes the output stream.
  modport master (
    output p_in, p_valid, out_ready,
    input  p_ready, out_data, out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Handshake qualification and occupancy update.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == (PtrW + 1)'(DEPTH));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
    // Empty FIFO presents zero rather than stale storage.
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dsp_post_round_sat.sv
// Post stage of the DSP slice: round/shift P, saturate to OUT_W, buffer, count saturations.
module dsp_post_round_sat #(
  parameter int unsigned IN_W     = dsp_pkg::IN_W,
  parameter int unsigned OUT_W    = dsp_pkg::OUT_W,
  parameter int unsigned SHIFT    = 12,
  parameter int unsigned ROUND_EN = 1,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  dsp_post_round_sat_if.slave bus,
  input  logic                clr_stat,
  output logic [15:0]         sat_cnt,
  output logic                sat_flag
);

  import dsp_pkg::*;

  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam longint      SatMaxL = sat_max(OUT_W);
  localparam longint      SatMinL = sat_min(OUT_W);
  localparam logic signed [IN_W:0] SatMax = SatMaxL[IN_W:0];
  localparam logic signed [IN_W:0] SatMin = SatMinL[IN_W:0];
  localparam logic signed [IN_W:0] RoundAdd =
      (ROUND_EN != 0) ? ((IN_W + 1)'(1) << (SHIFT - 1)) : '0;

  logic signed [IN_W:0] p_ext, s1_d, s1_q;
  logic                 s1_valid_q, s2_valid_q;
  logic [OUT_W-1:0]     s2_data_d, s2_data_q;
  logic                 s2_sat_d, s2_sat_q;
  logic [CntW-1:0]      fifo_count;
  logic [CntW:0]        credit_used;
  logic                 fifo_full, fifo_empty, fifo_pop, accept;
  logic                 sat_event;
  logic [15:0]          sat_cnt_d, sat_cnt_q;
  logic                 sat_flag_d, sat_flag_q;

  // S1 arithmetic: the extra top bit keeps the rounding add from overflowing.
  always_comb begin
    p_ext = {bus.p_in[IN_W-1], bus.p_in};
    s1_d  = (p_ext + RoundAdd) >>> SHIFT;
  end

  // S2 clamp to the signed OUT_W range.
  always_comb begin
    s2_data_d = s1_q[OUT_W-1:0];
    s2_sat_d  = 1'b0;
    if (s1_q > SatMax) begin
      s2_data_d = SatMax[OUT_W-1:0];
      s2_sat_d  = 1'b1;
    end else if (s1_q < SatMin) begin
      s2_data_d = SatMin[OUT_W-1:0];
      s2_sat_d  = 1'b1;
    end
  end

  // Credit: every sample in flight or buffered holds a FIFO slot, so nothing can stall.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q}
                + {{CntW{1'b0}}, s2_valid_q};
    bus.p_ready = !fifo_full && (credit_used < (CntW + 1)'(DEPTH));
    accept      = bus.p_valid && bus.p_ready;
    fifo_pop    = bus.out_valid && bus.out_ready;
  end

  // Two-stage pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_q <= s1_d;
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s2_valid_q),
    .data_i  (s2_data_q),
    .pop_i   (fifo_pop),
    .data_o  (bus.out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;

  // Saturation statistics: clear takes effect first, then the same-cycle event counts.
  always_comb begin
    sat_event  = s2_valid_q && s2_sat_q;
    sat_cnt_d  = clr_stat ? 16'h0000 : sat_cnt_q;
    sat_flag_d = clr_stat ? 1'b0 : sat_flag_q;
    if (sat_event) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_d != 16'hFFFF) sat_cnt_d = sat_cnt_d + 16'h0001;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_cnt  = sat_cnt_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_dsp_post_round_sat.sv
// Scoreboard bench for dsp_post_round_sat with a floor-division reference model.
module tb_dsp_post_round_sat;

  localparam int unsigned IN_W     = 48;
  localparam int unsigned OUT_W    = 18;
  localparam int unsigned SHIFT    = 12;
  localparam int unsigned ROUND_EN = 1;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_stat = 1'b0;
  logic [15:0] sat_cnt;
  logic        sat_flag;

  always #5 clk = ~clk;

  dsp_post_round_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  dsp_post_round_sat #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT),
    .ROUND_EN (ROUND_EN),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr_stat (clr_stat),
    .sat_cnt  (sat_cnt),
    .sat_flag (sat_flag)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [OUT_W-1:0] sb[$];
  int               sat_exp = 0;
  bit               prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  bit               tog_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: round-half-up, floor divide by 2^SHIFT, clamp to signed OUT_W.
  task automatic model(input logic [IN_W-1:0] p, output logic [OUT_W-1:0] res,
                       output bit sat);
    longint v, d, q, hi, lo;
    v  = longint'($signed(p));
    d  = longint'(1) <<< SHIFT;
    if (ROUND_EN != 0) v = v + d / 2;
    q  = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    sat = 1'b0;
    if (q > hi) begin q = hi; sat = 1'b1; end
    if (q < lo) begin q = lo; sat = 1'b1; end
    res = q[OUT_W-1:0];
  endtask

  task automatic push_exp(input logic [IN_W-1:0] p);
    logic [OUT_W-1:0] e;
    bit s;
    model(p, e, s);
    sb.push_back(e);
    if (s && sat_exp < 65535) sat_exp++;
  endtask

  // Offer one sample; it is accepted at the posedge following a negedge with p_ready high.
  task automatic send(input logic [IN_W-1:0] v);
    bit ok = 1'b0;
    bus.p_in    = v;
    bus.p_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.p_ready) begin ok = 1'b1; break; end
    end
    if (ok) push_exp(v);
    else begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: p_ready stayed 0, expected 1 within 64 cycles");
    end
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic lat_check(input string name, input logic [IN_W-1:0] v,
                           input logic [OUT_W-1:0] exp);
    send(v);
    chk({name, "_valid_k"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid_k1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid_k2"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_data"}, 64'(bus.out_data), 64'(exp));
    drain();
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1; clr_stat = 1'b1;
    @(posedge clk); #1; clr_stat = 1'b0;
    sat_exp = 0;
  endtask

  function automatic logic [IN_W-1:0] rnd_p();
    logic signed [IN_W-1:0] x;
    logic [63:0] r;
    r = {$urandom, $urandom};
    x = r[IN_W-1:0];
    case ($urandom_range(0, 3))
      0: ;
      1: x = x >>> $urandom_range(14, 34);
      2: x = 48'sd536866816 + $signed(48'($urandom_range(0, 8191))) - 48'sd4096;
      default: x = -48'sd536870912 + $signed(48'($urandom_range(0, 8191))) - 48'sd4096;
    endcase
    return x;
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks hold and credit.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("credit_bound", 64'(sb.size() <= DEPTH), 64'd1);
      if (prev_stall && bus.out_valid) chk("out_hold", 64'(bus.out_data), 64'(prev_data));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_output: got 0x%0h, expected no output", bus.out_data);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(sb.pop_front()));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] big_pos, big_neg;
    int acc, n;
    big_pos = 48'h0100_0000_0000;
    big_neg = 48'hFF00_0000_0000;
    bus.p_in = '0; bus.p_valid = 1'b0; bus.out_ready = 1'b1;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_p_ready", 64'(bus.p_ready), 64'd1);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // Rounding, with latency 2.
    lat_check("rnd_6144", 48'd6144, 18'd2);
    lat_check("rnd_m6144", 48'hFFFF_FFFF_E800, 18'h3FFFF);
    lat_check("rnd_2047", 48'd2047, 18'd0);
    lat_check("rnd_2048", 48'd2048, 18'd1);
    chk("rnd_no_sat", 64'(sat_cnt), 64'd0);

    // Saturation and clear.
    lat_check("sat_pos", big_pos, 18'h1FFFF);
    lat_check("sat_neg", big_neg, 18'h20000);
    chk("sat_cnt_2", 64'(sat_cnt), 64'd2);
    chk("sat_flag_1", 64'(sat_flag), 64'd1);
    clr_pulse();
    chk("clr_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("clr_sat_flag", 64'(sat_flag), 64'd0);

    // Backpressure: only DEPTH samples fit while the consumer stalls.
    bus.out_ready = 1'b0;
    acc = 0; n = 1;
    bus.p_in = 48'(4096 * n); bus.p_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.p_ready) begin push_exp(48'(4096 * n)); acc++; n++; end
      @(posedge clk); #1;
      bus.p_in = 48'(4096 * n);
    end
    bus.p_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_p_ready", 64'(bus.p_ready), 64'd0);
    chk("bp_head", 64'(bus.out_data), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = n; k <= 8; k++) send(48'(4096 * k));
    drain();

    // Random stream with the consumer toggling every cycle.
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk); #1;
          bus.out_ready = ~bus.out_ready;
        end
      end
      begin
        for (int i = 0; i < 300; i++) send(rnd_p());
        tog_en = 1'b0;
      end
    join
    drain();
    chk("rand_sat_cnt", 64'(sat_cnt), 64'(sat_exp));

    // Counter limit: no wrap past 0xFFFF.
    clr_pulse();
    for (int i = 0; i < 65537; i++) send(((i & 1) != 0) ? big_neg : big_pos);
    drain();
    chk("lim_sat_cnt_model", 64'(sat_cnt), 64'(sat_exp));
    chk("lim_sat_cnt", 64'(sat_cnt), 64'hFFFF);
    chk("lim_sat_flag", 64'(sat_flag), 64'd1);

    // Clear coincident with a saturated FIFO write (edge k+2).
    send(big_pos);
    @(posedge clk); #1; clr_stat = 1'b1;
    @(posedge clk); #1; clr_stat = 1'b0;
    sat_exp = 1;
    drain();
    chk("coinc_sat_cnt", 64'(sat_cnt), 64'd1);
    chk("coinc_sat_flag", 64'(sat_flag), 64'd1);

    // Asynchronous reset with three samples buffered.
    bus.out_ready = 1'b0;
    send(48'(4096 * 10));
    send(48'(4096 * 11));
    send(48'(4096 * 12));
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_p_ready", 64'(bus.p_ready), 64'd1);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_sat_cnt", 64'(sat_cnt), 64'd0);
    sb.delete();
    sat_exp = 0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(48'(4096 * 77));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_first", 64'(bus.out_data), 64'd77);
    drain();
    chk("post_rst_sat_flag", 64'(sat_flag), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_post_round_sat.md
Name: dsp_post_round_sat

Overview:
- Downstream stage of the DSP slice. Consumes the slice's 48-bit P result.
- Scales P by an arithmetic right shift with optional round-half-up, then saturates to a signed OUT_W word.
- Buffers results in a small output FIFO with valid/ready towards the next consumer.
- Counts saturation events so firmware and the bench can detect range problems.

Parameters:
- IN_W, 48, width of the P input (signed two's complement).
- OUT_W, 18, width of the output word (signed).
- SHIFT, 12, right-shift amount. Legal range 1..IN_W-OUT_W.
- ROUND_EN, 1. When 1, add 2^(SHIFT-1) before shifting; when 0, truncate toward -inf.
- DEPTH, 4, output FIFO depth. Power of two, 2 or more.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p_in  in  IN_W  signed P value from the DSP slice.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  stage can accept p_in this cycle.
- clr_stat  in  1  synchronous clear of sat_cnt and sat_flag.
- out_data  out  OUT_W  head of the output FIFO.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- sat_cnt  out  16  number of saturated samples; saturates at 0xFFFF.
- sat_flag  out  1  sticky: at least one sample saturated since reset/clear.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Stage valids, FIFO pointers and count go to 0.
  - out_valid=0, out_data=0, p_ready=1, sat_cnt=0, sat_flag=0.
- Accept: a sample is accepted at a rising edge where p_valid && p_ready.
- Stage 1 (S1), registered:
  - r = sign-extend p_in to IN_W+1 bits.
  - Add (1<<(SHIFT-1)) if ROUND_EN.
  - Arithmetic shift right by SHIFT. The extra bit prevents overflow of the round add.
- Stage 2 (S2), registered:
  - If r > 2^(OUT_W-1)-1, output 0x1FFFF (OUT_W=18) and mark saturated.
  - If r < -2^(OUT_W-1), output 0x20000 and mark saturated.
  - Otherwise output r[OUT_W-1:0].
  - The result is written into the FIFO on the edge after S2 holds it.
- Latency: a sample accepted at edge k is at the FIFO head with out_valid=1 after edge k+2, provided the FIFO was empty.
- Throughput: one sample per cycle while out_ready=1.
- Credit flow control:
  - p_ready = (fifo_count + s1_valid + s2_valid) < DEPTH.
  - The pipeline never stalls internally, and no sample is ever dropped.
- FIFO:
  - Push and pop in the same cycle: count is unchanged and data ordering is preserved.
  - Pop only when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
  - out_data holds its value while out_valid && !out_ready.
- Statistics:
  - sat_cnt increments by 1 on each saturated FIFO write and sticks at 0xFFFF.
  - sat_flag is set on the same event.
  - If clr_stat and a saturation occur in the same cycle, the counter is cleared and then counts that event: sat_cnt=1, sat_flag=1.
- Reset mid-operation: all in-flight and buffered samples are discarded; no partial output appears after reset.
- p_valid while !p_ready is ignored; the upstream must hold the value.

Decomposition:
- Shared package dsp_pkg:
  - Constants IN_W=48 and OUT_W=18.
  - Functions sat_max/sat_min(width).
  - Typedefs p_word_t (signed [47:0]) and out_word_t (signed [17:0]).
- Sub-module sync_fifo (DEPTH, WIDTH):
  - Pointer-based, with count, full and empty.
  - Reusable elsewhere in the DSP path.
- The top level holds S1, S2, the credit logic and the statistics.

Test Plan:
- Rounding:
  - p_in=6144 (1.5·2^12) → out_data=2.
  - p_in=-6144 → -1 (0x3FFFF).
  - p_in=2047 → 0; p_in=2048 → 1.
  - All at latency 2 with out_ready=1.
- Saturation:
  - p_in=2^40 → 0x1FFFF; p_in=-2^40 → 0x20000.
  - sat_cnt=2, sat_flag=1.
  - Pulse clr_stat → sat_cnt=0, sat_flag=0.
- Backpressure: out_ready=0 and stream p_in=4096·n for n=1..8.
  - Exactly 4 are accepted, then p_ready=0.
  - Raise out_ready → outputs 1,2,3,4,5,… in order with no loss or duplication.
- Simultaneous push/pop:
  - Continuous stream with out_ready toggling every cycle.
  - FIFO count never exceeds DEPTH; output sequence matches the input sequence.
- Counter limit:
  - Preload-free run of 65537 saturating samples → sat_cnt=0xFFFF, no wrap.
  - clr_stat coincident with a saturation → sat_cnt=1.
- Reset mid-stream:
  - Assert rst asynchronously (between edges) with 3 samples buffered.
  - Outputs go to reset values immediately: out_valid=0, p_ready=1.
  - The first sample after release is the first one output.
